// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32-bit unsigned multiplier sequencer driving a shared
// single-cycle ALU. Returns the low N bits of a*b and an exact overflow flag.

package alu_mul_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SLL = 4'h1
    } alu_control_t;
endpackage

module alu_mul_sequencer
    import alu_mul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] product,
    output logic         ovf,
    output logic         busy,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output alu_control_t alu_control,
    input  logic [N-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] acc, acc_nxt;
    logic [N-1:0] mcand, mcand_nxt;
    logic [N-1:0] mplier, mplier_nxt;
    logic         ovf_r, ovf_nxt;

    // State and datapath registers; reset clears everything asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            ovf_r  <= ovf_nxt;
        end
    end

    // Next-state, register updates and ALU drive (ALU drive never uses alu_result)
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        ovf_nxt     = ovf_r;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;

        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    acc_nxt    = '0;
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    ovf_nxt    = 1'b0;
                    state_nxt  = S_ADD;
                end
            end
            S_ADD: begin
                alu_a = acc;
                alu_b = mcand;
                if (mplier == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    if (mplier[0]) begin
                        acc_nxt = alu_result;
                        // Wrapped sum means a carry out of bit N-1
                        if (alu_result < acc) begin
                            ovf_nxt = 1'b1;
                        end
                    end
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                alu_a       = mcand;
                alu_b       = {{(N-1){1'b0}}, 1'b1};
                alu_control = ALU_SLL;
                mcand_nxt   = alu_result;
                mplier_nxt  = mplier >> 1;
                // A bit shifted out of mcand matters only if a later multiplier bit would add it
                if (mcand[N-1] && ((mplier >> 1) != '0)) begin
                    ovf_nxt = 1'b1;
                end
                state_nxt = S_ADD;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign product   = acc;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: behavioural ALU, a cycle-level
// reference model derived from 64-bit arithmetic and latency rules, a
// per-cycle compare process, and directed literal cases.

module tb_alu_mul_sequencer;
    import alu_mul_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  product;
    logic         ovf;
    logic         busy;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    alu_control_t alu_control;
    logic [31:0]  alu_result;

    int checks   = 0;
    int failures = 0;

    alu_mul_sequencer #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .ovf        (ovf),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_control(alu_control),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    // Behavioural single-cycle ALU
    always_comb begin
        if (alu_control == ALU_SLL) alu_result = alu_a << alu_b[4:0];
        else                        alu_result = alu_a + alu_b;
    end

    function automatic logic [63:0] ref_full(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic int ref_lat(input logic [31:0] y);
        int k;
        k = -1;
        for (int i = 0; i < 32; i++) if (y[i]) k = i;
        return (k < 0) ? 1 : 2 * (k + 1) + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 computing (m_rem edges left), 2 holding result
    int          m_phase;
    int          m_rem;
    logic [31:0] m_prod;
    logic        m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_rem   <= 0;
            m_prod  <= '0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_rem   <= ref_lat(b);
                    m_prod  <= ref_full(a, b)[31:0];
                    m_ovf   <= (ref_full(a, b)[63:32] != 32'd0);
                end
                1: begin
                    if (m_rem == 1) m_phase <= 2;
                    m_rem <= m_rem - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", 64'(in_ready), 64'(m_phase == 0));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                chk("product", 64'(product), 64'(m_prod));
                chk("ovf", 64'(ovf), 64'(m_ovf));
            end
            // Computing alternates ADD/SHIFT starting and ending on ADD (odd m_rem)
            if (m_phase == 1 && (m_rem % 2 == 0)) begin
                chk("alu_control_sll", 64'(alu_control), 64'(ALU_SLL));
                chk("alu_b_shift", 64'(alu_b), 64'd1);
            end else begin
                chk("alu_control_add", 64'(alu_control), 64'(ALU_ADD));
            end
            if (m_phase != 1) begin
                chk("alu_a_idle", 64'(alu_a), 64'd0);
                chk("alu_b_idle", 64'(alu_b), 64'd0);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_control", 64'(alu_control), 64'(ALU_ADD));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("wait_idle_timeout", 64'(in_ready), 64'd1);
    endtask

    // One transaction: accept, wait for result (bounded), stall, release
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [31:0] ep, input logic eo, input int elat,
                         input int stall);
        int cyc;
        wait_idle();
        @(negedge clk);
        a = op_a; b = op_b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom;
        while (out_valid !== 1'b1 && cyc < 80) begin
            in_valid = 1'($urandom % 2);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("latency", 64'(cyc), 64'(elat));
        chk("lit_product", 64'(product), 64'(ep));
        chk("lit_ovf", 64'(ovf), 64'(eo));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom % 2);
            a = $urandom; b = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("stall_product", 64'(product), 64'(ep));
            chk("stall_ovf", 64'(ovf), 64'(eo));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] full;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #3;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed literal cases
        do_op(32'd3, 32'd5, 32'd15, 1'b0, 7, 0);
        do_op(32'h12345678, 32'd0, 32'd0, 1'b0, 1, 0);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 65, 0);
        do_op(32'h00010000, 32'h00010000, 32'd0, 1'b1, 35, 0);
        do_op(32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 35, 0);
        do_op(32'd3, 32'd5, 32'd15, 1'b0, 7, 10);

        // Asynchronous reset in the middle of a SHIFT
        wait_idle();
        @(negedge clk);
        a = 32'h9ABCDEF1; b = 32'h80000000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (alu_control != ALU_SLL && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reached_shift", 64'(alu_control), 64'(ALU_SLL));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd7, 32'd6, 32'd42, 1'b0, 7, 0);

        // Randomized operations checked against plain 64-bit arithmetic
        for (int t = 0; t < 40; t++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if (t % 7 == 0) rb = '0;
            full = ref_full(ra, rb);
            do_op(ra, rb, full[31:0], (full[63:32] != 32'd0), ref_lat(rb),
                  $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
